// File: rtl/maverick_issue_stage_pkg.sv
// Shared maverickOne definitions: register-file geometry plus the issue-stage packet and buffer state types.
package maverickOne_pkg;

   localparam int NUM_REGS        = 32;
   localparam int XLEN            = 32;
   localparam int AW              = $clog2(NUM_REGS);
   localparam int ISSUE_PAYLOAD_W = 32;

   typedef struct packed {
      logic [ISSUE_PAYLOAD_W-1:0] payload;
      logic [AW-1:0]              rd_addr;
      logic                       rd_we;
      logic [2:0][XLEN-1:0]       op_data;
   } issue_pkt_t;

   typedef enum logic {
      BUF_EMPTY = 1'b0,
      BUF_FULL  = 1'b1
   } buf_state_e;

endpackage

// File: rtl/maverick_issue_stage_hazard_check.sv
// Per-source RAW / destination WAW hazard detection against regfile locks.
// Writeback forwarding is compiled in only when ISSUE_FWD_EN is defined.
module maverick_hazard_check
   import maverickOne_pkg::*;
(
   input  logic [2:0][AW-1:0] rs_addr,
   input  logic [2:0]         rs_use,
   input  logic [AW-1:0]      rd_addr,
   input  logic               rd_we,
   input  logic [NUM_REGS-1:0] locks,
   input  logic               wb_en,
   input  logic [AW-1:0]      wb_addr,
   output logic [2:0]         raw_hz,
   output logic               waw_hz,
   output logic [2:0]         fwd_sel
);

   logic rd_fwd;

   // x0 is never locked, so it can never be a hazard even if the regfile misreports it.
   always_comb begin
      raw_hz  = '0;
      fwd_sel = '0;
      rd_fwd  = 1'b0;
`ifdef ISSUE_FWD_EN
      rd_fwd = wb_en && (wb_addr == rd_addr) && (rd_addr != '0);
`endif
      for (int k = 0; k < 3; k++) begin
`ifdef ISSUE_FWD_EN
         fwd_sel[k] = rs_use[k] && wb_en && (wb_addr == rs_addr[k]) && (rs_addr[k] != '0);
`endif
         raw_hz[k] = rs_use[k] && (rs_addr[k] != '0) && locks[rs_addr[k]] && !fwd_sel[k];
      end
      waw_hz = rd_we && (rd_addr != '0) && locks[rd_addr] && !rd_fwd;
   end

`ifndef ISSUE_FWD_EN
   logic unused_wb;
   assign unused_wb = ^{wb_en, wb_addr};
`endif

endmodule

// File: rtl/maverick_issue_stage.sv
// Issue stage ahead of maverickOne_regfile: hazard check, operand read, rd lock and a single-entry output buffer.
// Define ISSUE_FWD_EN to let a same-cycle writeback satisfy RAW/WAW hazards instead of stalling.
module maverick_issue_stage
   import maverickOne_pkg::*;
#(
   parameter int PAYLOAD_W   = ISSUE_PAYLOAD_W,
   parameter int STALL_CNT_W = 16
) (
   input  logic                   clk_i,
   input  logic                   arst_ni,
   input  logic                   instr_valid_i,
   output logic                   instr_ready_o,
   input  logic [PAYLOAD_W-1:0]   payload_i,
   input  logic [AW-1:0]          rd_addr_i,
   input  logic                   rd_we_i,
   input  logic [2:0][AW-1:0]     rs_addr_i,
   input  logic [2:0]             rs_use_i,
   input  logic [NUM_REGS-1:0]    locks_i,
   output logic [AW-1:0]          rs1_addr_o,
   output logic [AW-1:0]          rs2_addr_o,
   output logic [AW-1:0]          rs3_addr_o,
   input  logic [XLEN-1:0]        rs1_data_i,
   input  logic [XLEN-1:0]        rs2_data_i,
   input  logic [XLEN-1:0]        rs3_data_i,
   output logic                   wr_lock_en_o,
   output logic [AW-1:0]          wr_lock_addr_o,
   input  logic                   wb_en_i,
   input  logic [AW-1:0]          wb_addr_i,
   input  logic [XLEN-1:0]        wb_data_i,
   output logic                   issue_valid_o,
   input  logic                   issue_ready_i,
   output logic [PAYLOAD_W-1:0]   payload_o,
   output logic [AW-1:0]          rd_addr_o,
   output logic                   rd_we_o,
   output logic [2:0][XLEN-1:0]   op_data_o,
   output logic [STALL_CNT_W-1:0] stall_cnt_o
);

   buf_state_e           state_q, state_d;
   issue_pkt_t           pkt_q, pkt_d;
   logic [2:0]           raw_hz, fwd_sel;
   logic                 waw_hz, hazard, space, fire;
   logic [2:0][XLEN-1:0] rs_data;

   assign rs1_addr_o = rs_addr_i[0];
   assign rs2_addr_o = rs_addr_i[1];
   assign rs3_addr_o = rs_addr_i[2];
   assign rs_data    = {rs3_data_i, rs2_data_i, rs1_data_i};

   maverick_hazard_check u_hazard (
      .rs_addr (rs_addr_i),
      .rs_use  (rs_use_i),
      .rd_addr (rd_addr_i),
      .rd_we   (rd_we_i),
      .locks   (locks_i),
      .wb_en   (wb_en_i),
      .wb_addr (wb_addr_i),
      .raw_hz  (raw_hz),
      .waw_hz  (waw_hz),
      .fwd_sel (fwd_sel)
   );

   assign hazard         = (|raw_hz) || waw_hz;
   assign space          = (state_q == BUF_EMPTY) || issue_ready_i;
   assign instr_ready_o  = space && !hazard;
   assign fire           = instr_valid_i && instr_ready_o;
   // Same-cycle unlock of rd by writeback loses to this lock inside the regfile.
   assign wr_lock_en_o   = fire && rd_we_i && (rd_addr_i != '0);
   assign wr_lock_addr_o = rd_addr_i;

   // Payloads wider than the package packet field are truncated in the buffer.
   always_comb begin
      pkt_d         = '0;
      pkt_d.payload = ISSUE_PAYLOAD_W'(payload_i);
      pkt_d.rd_addr = rd_addr_i;
      pkt_d.rd_we   = rd_we_i;
      for (int k = 0; k < 3; k++) begin
         if (fwd_sel[k])
            pkt_d.op_data[k] = wb_data_i;
         else if (rs_use_i[k])
            pkt_d.op_data[k] = rs_data[k];
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         BUF_EMPTY: if (fire) state_d = BUF_FULL;
         BUF_FULL:  if (issue_ready_i && !fire) state_d = BUF_EMPTY;
         default:   state_d = BUF_EMPTY;
      endcase
   end

   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         state_q     <= BUF_EMPTY;
         pkt_q       <= '0;
         stall_cnt_o <= '0;
      end else begin
         state_q <= state_d;
         if (fire)
            pkt_q <= pkt_d;
         if (instr_valid_i && hazard && (stall_cnt_o != '1))
            stall_cnt_o <= stall_cnt_o + 1'b1;
      end
   end

   assign issue_valid_o = (state_q == BUF_FULL);
   assign payload_o     = PAYLOAD_W'(pkt_q.payload);
   assign rd_addr_o     = pkt_q.rd_addr;
   assign rd_we_o       = pkt_q.rd_we;
   assign op_data_o     = pkt_q.op_data;

endmodule

// File: tb/tb_maverick_issue_stage.sv
// Self-checking bench for maverick_issue_stage with a small lock/regfile environment and an expected-packet queue.
module tb_maverick_issue_stage;
   import maverickOne_pkg::*;

   logic clk_i = 1'b0;
   logic arst_ni = 1'b0;
   always #5 clk_i = ~clk_i;

   logic                 instr_valid_i, instr_ready_o, rd_we_i;
   logic [31:0]          payload_i, payload_o;
   logic [AW-1:0]        rd_addr_i, rs1_addr_o, rs2_addr_o, rs3_addr_o, wr_lock_addr_o, wb_addr_i, rd_addr_o;
   logic [2:0][AW-1:0]   rs_addr_i;
   logic [2:0]           rs_use_i;
   logic [NUM_REGS-1:0]  locks_i;
   logic [XLEN-1:0]      rs1_data_i, rs2_data_i, rs3_data_i, wb_data_i;
   logic                 wr_lock_en_o, wb_en_i, issue_valid_o, issue_ready_i, rd_we_o;
   logic [2:0][XLEN-1:0] op_data_o;
   logic [7:0]           stall_cnt_o;

   maverick_issue_stage #(.PAYLOAD_W(32), .STALL_CNT_W(8)) dut (
      .clk_i(clk_i), .arst_ni(arst_ni),
      .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o),
      .payload_i(payload_i), .rd_addr_i(rd_addr_i), .rd_we_i(rd_we_i),
      .rs_addr_i(rs_addr_i), .rs_use_i(rs_use_i), .locks_i(locks_i),
      .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o), .rs3_addr_o(rs3_addr_o),
      .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .rs3_data_i(rs3_data_i),
      .wr_lock_en_o(wr_lock_en_o), .wr_lock_addr_o(wr_lock_addr_o),
      .wb_en_i(wb_en_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
      .issue_valid_o(issue_valid_o), .issue_ready_i(issue_ready_i),
      .payload_o(payload_o), .rd_addr_o(rd_addr_o), .rd_we_o(rd_we_o),
      .op_data_o(op_data_o), .stall_cnt_o(stall_cnt_o)
   );

   // Regfile stand-in: lock wins over a same-cycle writeback unlock of the same register.
   logic [XLEN-1:0]     regs [NUM_REGS];
   logic [NUM_REGS-1:0] wrote;
   always @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         locks_i <= '0;
         wrote   <= '0;
      end else begin
         if (wb_en_i) begin
            locks_i[wb_addr_i] <= 1'b0;
            regs[wb_addr_i]    <= wb_data_i;
            wrote[wb_addr_i]   <= 1'b1;
         end
         if (wr_lock_en_o && wr_lock_addr_o != '0)
            locks_i[wr_lock_addr_o] <= 1'b1;
      end
   end

   function automatic logic [XLEN-1:0] seed(input logic [AW-1:0] a);
      if (a == 5'd0) return '0;
      if (a == 5'd5) return 32'hDEAD_BEEF;
      return 32'h1000_0000 | 32'(a);
   endfunction

   always_comb begin
      rs1_data_i = wrote[rs_addr_i[0]] ? regs[rs_addr_i[0]] : seed(rs_addr_i[0]);
      rs2_data_i = wrote[rs_addr_i[1]] ? regs[rs_addr_i[1]] : seed(rs_addr_i[1]);
      rs3_data_i = wrote[rs_addr_i[2]] ? regs[rs_addr_i[2]] : seed(rs_addr_i[2]);
   end

   issue_pkt_t obs, exp_pkt;
   assign obs = {payload_o, rd_addr_o, rd_we_o, op_data_o};
   issue_pkt_t sb[$];
   int n_checks = 0;
   int n_fail   = 0;
   logic [7:0] stall_before;

   task automatic drive(input logic [31:0] pl, input logic [4:0] rd, input logic we,
                        input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] a3,
                        input logic [2:0] use_f);
      instr_valid_i = 1'b1; payload_i = pl; rd_addr_i = rd; rd_we_i = we;
      rs_addr_i[0] = a1; rs_addr_i[1] = a2; rs_addr_i[2] = a3; rs_use_i = use_f;
   endtask

   task automatic idle();
      instr_valid_i = 1'b0; rd_we_i = 1'b0; rs_use_i = '0;
   endtask

   task automatic expect_pkt(input logic [31:0] pl, input logic [4:0] rd, input logic we,
                             input logic [31:0] o1, input logic [31:0] o2, input logic [31:0] o3);
      issue_pkt_t p;
      p.payload = pl; p.rd_addr = rd; p.rd_we = we;
      p.op_data[0] = o1; p.op_data[1] = o2; p.op_data[2] = o3;
      sb.push_back(p);
   endtask

   task automatic test_reset();
      idle(); issue_ready_i = 1'b1; wb_en_i = 1'b0; wb_addr_i = '0; wb_data_i = '0;
      payload_i = '0; rd_addr_i = '0; rs_addr_i = '0;
      repeat (2) @(negedge clk_i);
      n_checks++; if (issue_valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid: got %b expected 0", issue_valid_o); end
      n_checks++; if (stall_cnt_o !== 8'd0) begin n_fail++; $display("[TB] FAIL reset_stall: got %0d expected 0", stall_cnt_o); end
      n_checks++; if (obs !== '0) begin n_fail++; $display("[TB] FAIL reset_buffer: got %h expected 0", obs); end
      arst_ni = 1'b1;
      @(negedge clk_i);
   endtask

   task automatic test_basic();
      drive(32'hA1, 5'd7, 1'b1, 5'd5, 5'd0, 5'd0, 3'b001);
      #1;
      n_checks++; if (instr_ready_o !== 1'b1) begin n_fail++; $display("[TB] FAIL basic_ready: got %b expected 1", instr_ready_o); end
      n_checks++; if ({wr_lock_en_o, wr_lock_addr_o} !== {1'b1, 5'd7}) begin n_fail++; $display("[TB] FAIL basic_lock: got %b/%0d expected 1/7", wr_lock_en_o, wr_lock_addr_o); end
      n_checks++; if (rs1_addr_o !== 5'd5) begin n_fail++; $display("[TB] FAIL basic_rs1_addr: got %0d expected 5", rs1_addr_o); end
      expect_pkt(32'hA1, 5'd7, 1'b1, 32'hDEAD_BEEF, 32'h0, 32'h0);
      @(negedge clk_i); idle();
      n_checks++; if (issue_valid_o !== 1'b1) begin n_fail++; $display("[TB] FAIL basic_valid: got %b expected 1", issue_valid_o); end
      exp_pkt = sb.pop_front();
      n_checks++; if (obs !== exp_pkt) begin n_fail++; $display("[TB] FAIL basic_pkt: got %h expected %h", obs, exp_pkt); end
   endtask

   task automatic test_back_to_back();
      stall_before = stall_cnt_o;
      drive(32'hB2, 5'd8, 1'b1, 5'd0, 5'd7, 5'd0, 3'b010);
      for (int i = 0; i < 3; i++) begin
         #1;
         n_checks++; if (instr_ready_o !== 1'b0) begin n_fail++; $display("[TB] FAIL raw_stall[%0d]: got %b expected 0", i, instr_ready_o); end
         @(negedge clk_i);
      end
      n_checks++; if (stall_cnt_o !== 8'(stall_before + 8'd3)) begin n_fail++; $display("[TB] FAIL raw_stall_cnt: got %0d expected %0d", stall_cnt_o, stall_before + 8'd3); end
      wb_en_i = 1'b1; wb_addr_i = 5'd7; wb_data_i = 32'h1234;
      #1;
`ifdef ISSUE_FWD_EN
      n_checks++; if (instr_ready_o !== 1'b1) begin n_fail++; $display("[TB] FAIL raw_fwd_ready: got %b expected 1", instr_ready_o); end
      expect_pkt(32'hB2, 5'd8, 1'b1, 32'h0, 32'h1234, 32'h0);
      @(negedge clk_i); wb_en_i = 1'b0; idle();
`else
      n_checks++; if (instr_ready_o !== 1'b0) begin n_fail++; $display("[TB] FAIL raw_wb_cycle_ready: got %b expected 0", instr_ready_o); end
      @(negedge clk_i); wb_en_i = 1'b0;
      #1;
      n_checks++; if (instr_ready_o !== 1'b1) begin n_fail++; $display("[TB] FAIL raw_after_wb_ready: got %b expected 1", instr_ready_o); end
      expect_pkt(32'hB2, 5'd8, 1'b1, 32'h0, 32'h1234, 32'h0);
      @(negedge clk_i); idle();
`endif
      n_checks++; if (issue_valid_o !== 1'b1) begin n_fail++; $display("[TB] FAIL raw_valid: got %b expected 1", issue_valid_o); end
      exp_pkt = sb.pop_front();
      n_checks++; if (obs !== exp_pkt) begin n_fail++; $display("[TB] FAIL raw_pkt: got %h expected %h", obs, exp_pkt); end
   endtask

   task automatic test_waw();
      drive(32'hC3, 5'd9, 1'b1, 5'd0, 5'd0, 5'd0, 3'b000);
      #1;
      n_checks++; if (instr_ready_o !== 1'b1) begin n_fail++; $display("[TB] FAIL waw_first_ready: got %b expected 1", instr_ready_o); end
      expect_pkt(32'hC3, 5'd9, 1'b1, 32'h0, 32'h0, 32'h0);
      @(negedge clk_i);
      exp_pkt = sb.pop_front();
      n_checks++; if (obs !== exp_pkt || issue_valid_o !== 1'b1) begin n_fail++; $display("[TB] FAIL waw_first_pkt: got %h/%b expected %h/1", obs, issue_valid_o, exp_pkt); end
      drive(32'hD4, 5'd9, 1'b1, 5'd0, 5'd0, 5'd0, 3'b000);
      for (int i = 0; i < 2; i++) begin
         #1;
         n_checks++; if (instr_ready_o !== 1'b0) begin n_fail++; $display("[TB] FAIL waw_stall[%0d]: got %b expected 0", i, instr_ready_o); end
         @(negedge clk_i);
      end
      wb_en_i = 1'b1; wb_addr_i = 5'd9; wb_data_i = 32'h55;
      #1;
`ifdef ISSUE_FWD_EN
      n_checks++; if (instr_ready_o !== 1'b1) begin n_fail++; $display("[TB] FAIL waw_fwd_ready: got %b expected 1", instr_ready_o); end
      expect_pkt(32'hD4, 5'd9, 1'b1, 32'h0, 32'h0, 32'h0);
      @(negedge clk_i); wb_en_i = 1'b0; idle();
`else
      n_checks++; if (instr_ready_o !== 1'b0) begin n_fail++; $display("[TB] FAIL waw_wb_cycle_ready: got %b expected 0", instr_ready_o); end
      @(negedge clk_i); wb_en_i = 1'b0;
      #1;
      n_checks++; if (instr_ready_o !== 1'b1) begin n_fail++; $display("[TB] FAIL waw_after_wb_ready: got %b expected 1", instr_ready_o); end
      expect_pkt(32'hD4, 5'd9, 1'b1, 32'h0, 32'h0, 32'h0);
      @(negedge clk_i); idle();
`endif
      exp_pkt = sb.pop_front();
      n_checks++; if (obs !== exp_pkt || issue_valid_o !== 1'b1) begin n_fail++; $display("[TB] FAIL waw_pkt: got %h/%b expected %h/1", obs, issue_valid_o, exp_pkt); end
      @(negedge clk_i);
   endtask

   task automatic test_hold();
      issue_ready_i = 1'b0;
      drive(32'hE5, 5'd10, 1'b1, 5'd5, 5'd0, 5'd0, 3'b001);
      #1;
      n_checks++; if (instr_ready_o !== 1'b1) begin n_fail++; $display("[TB] FAIL hold_fill_ready: got %b expected 1", instr_ready_o); end
      expect_pkt(32'hE5, 5'd10, 1'b1, 32'hDEAD_BEEF, 32'h0, 32'h0);
      @(negedge clk_i);
      drive(32'hF6, 5'd11, 1'b1, 5'd0, 5'd0, 5'd0, 3'b000);
      for (int i = 0; i < 5; i++) begin
         #1;
         n_checks++; if (instr_ready_o !== 1'b0) begin n_fail++; $display("[TB] FAIL hold_ready[%0d]: got %b expected 0", i, instr_ready_o); end
         n_checks++; if (obs !== sb[0] || issue_valid_o !== 1'b1) begin n_fail++; $display("[TB] FAIL hold_stable[%0d]: got %h/%b expected %h/1", i, obs, issue_valid_o, sb[0]); end
         @(negedge clk_i);
      end
      issue_ready_i = 1'b1;
      #1;
      n_checks++; if (instr_ready_o !== 1'b1) begin n_fail++; $display("[TB] FAIL hold_release_ready: got %b expected 1", instr_ready_o); end
      exp_pkt = sb.pop_front();
      n_checks++; if (obs !== exp_pkt) begin n_fail++; $display("[TB] FAIL hold_drain_pkt: got %h expected %h", obs, exp_pkt); end
      expect_pkt(32'hF6, 5'd11, 1'b1, 32'h0, 32'h0, 32'h0);
      @(negedge clk_i); idle();
      exp_pkt = sb.pop_front();
      n_checks++; if (obs !== exp_pkt || issue_valid_o !== 1'b1) begin n_fail++; $display("[TB] FAIL hold_b2b_pkt: got %h/%b expected %h/1", obs, issue_valid_o, exp_pkt); end
   endtask

   task automatic test_zero();
      drive(32'h77, 5'd0, 1'b1, 5'd0, 5'd3, 5'd0, 3'b001);
      #1;
      n_checks++; if (instr_ready_o !== 1'b1) begin n_fail++; $display("[TB] FAIL zero_ready: got %b expected 1", instr_ready_o); end
      n_checks++; if (wr_lock_en_o !== 1'b0) begin n_fail++; $display("[TB] FAIL zero_lock: got %b expected 0", wr_lock_en_o); end
      expect_pkt(32'h77, 5'd0, 1'b1, 32'h0, 32'h0, 32'h0);
      @(negedge clk_i); idle();
      exp_pkt = sb.pop_front();
      n_checks++; if (obs !== exp_pkt || issue_valid_o !== 1'b1) begin n_fail++; $display("[TB] FAIL zero_pkt: got %h/%b expected %h/1", obs, issue_valid_o, exp_pkt); end
      @(negedge clk_i);
   endtask

   task automatic test_saturation();
      issue_ready_i = 1'b0;
      drive(32'h97, 5'd12, 1'b1, 5'd0, 5'd0, 5'd0, 3'b000);
      #1;
      n_checks++; if (instr_ready_o !== 1'b1) begin n_fail++; $display("[TB] FAIL sat_fill_ready: got %b expected 1", instr_ready_o); end
      expect_pkt(32'h97, 5'd12, 1'b1, 32'h0, 32'h0, 32'h0);
      @(negedge clk_i);
      drive(32'hA8, 5'd13, 1'b1, 5'd8, 5'd0, 5'd0, 3'b001);
      repeat (300) @(negedge clk_i);
      n_checks++; if (stall_cnt_o !== 8'hFF) begin n_fail++; $display("[TB] FAIL sat_count: got %0d expected 255", stall_cnt_o); end
      n_checks++; if (obs !== sb[0] || issue_valid_o !== 1'b1) begin n_fail++; $display("[TB] FAIL sat_buffer: got %h/%b expected %h/1", obs, issue_valid_o, sb[0]); end
      arst_ni = 1'b0;
      #1;
      n_checks++; if (issue_valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset_valid: got %b expected 0", issue_valid_o); end
      n_checks++; if (stall_cnt_o !== 8'd0) begin n_fail++; $display("[TB] FAIL midreset_stall: got %0d expected 0", stall_cnt_o); end
      n_checks++; if (obs !== '0) begin n_fail++; $display("[TB] FAIL midreset_buffer: got %h expected 0", obs); end
      sb.delete();
      idle();
      @(negedge clk_i); arst_ni = 1'b1;
      @(negedge clk_i);
      n_checks++; if (issue_valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL postreset_valid: got %b expected 0", issue_valid_o); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_waw();
      test_hold();
      test_zero();
      test_saturation();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
